// File: rtl/pingpong_conv_reader.sv
// Purpose: read-side master of the ping-pong feature buffer; sweeps every KxK window in raster order to the PE array.
// Latency: address issued at cycle t, buffer data at t+1, registered beat on o_win_data at t+2 when unstalled.
// Backpressure: valid/ready toward the PE array; a 1-entry skid absorbs the in-flight read and address issue pauses when full.
module pingpong_conv_reader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16,
    parameter int IMG_W  = 4,
    parameter int IMG_H  = 4,
    parameter int K      = 3,
    parameter int STRIDE = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_pl_buffer_ready,
    output logic [ADDR_W-1:0] o_conv_addr,
    input  logic [DATA_W-1:0] i_conv_dout,
    output logic              o_switch_pingpong,
    output logic [DATA_W-1:0] o_win_data,
    output logic              o_win_vld,
    input  logic              i_pe_ready,
    output logic              o_win_last,
    output logic              o_frame_done
);

    localparam int OUT_W = (IMG_W - K) / STRIDE + 1;
    localparam int OUT_H = (IMG_H - K) / STRIDE + 1;

    localparam logic [ADDR_W-1:0] KM1   = ADDR_W'(K - 1);
    localparam logic [ADDR_W-1:0] OWM1  = ADDR_W'(OUT_W - 1);
    localparam logic [ADDR_W-1:0] OHM1  = ADDR_W'(OUT_H - 1);
    localparam logic [ADDR_W-1:0] STR_A = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] IMW_A = ADDR_W'(IMG_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BUF,
        S_READ,
        S_DRAIN,
        S_SWITCH
    } state_t;

    state_t state_q;
    logic   switch_q;

    // window position counters, innermost kx
    logic [ADDR_W-1:0] kx_q, ky_q, ox_q, oy_q;

    // read pipeline: in-flight marker, skid entry, output register
    logic              inflight_q, inflight_last_q;
    logic              skid_vld_q, skid_last_q;
    logic [DATA_W-1:0] skid_dat_q;
    logic              out_vld_q, out_last_q;
    logic [DATA_W-1:0] out_dat_q;

    logic       win_last_w, frame_last_w, accept_w, room_w, issue_w;
    logic [1:0] occ_w;

    // Issue control: a new read must still find a slot two cycles later even if nothing drains,
    // so we count every beat already owed to the output register / skid pair.
    always_comb begin
        win_last_w   = (kx_q == KM1) && (ky_q == KM1);
        frame_last_w = win_last_w && (ox_q == OWM1) && (oy_q == OHM1);
        accept_w     = out_vld_q && i_pe_ready;
        occ_w        = {1'b0, out_vld_q} + {1'b0, skid_vld_q} + {1'b0, inflight_q};
        room_w       = (occ_w <= 2'd1) || (accept_w && (occ_w == 2'd2));
        issue_w      = (state_q == S_READ) && room_w;
    end

    // Buffer address of the current window pixel; stays put while issue is paused.
    always_comb begin
        o_conv_addr = '0;
        o_conv_addr = (oy_q * STR_A + ky_q) * IMW_A + (ox_q * STR_A + kx_q);
    end

    // Frame sequencing FSM with registered bank-switch / frame-done pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            switch_q <= 1'b0;
        end else begin
            switch_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_en) state_q <= S_WAIT_BUF;
                end
                S_WAIT_BUF: begin
                    if (i_pl_buffer_ready) state_q <= S_READ;
                end
                S_READ: begin
                    if (issue_w && frame_last_w) state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    // only the final beat can be left once nothing is in flight or parked
                    if (accept_w && !skid_vld_q && !inflight_q) begin
                        state_q  <= S_SWITCH;
                        switch_q <= 1'b1;
                    end
                end
                S_SWITCH: begin
                    state_q <= i_en ? S_WAIT_BUF : S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Window counters advance once per issued address and wrap back to 0 after the last window.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            kx_q <= '0;
            ky_q <= '0;
            ox_q <= '0;
            oy_q <= '0;
        end else if (issue_w) begin
            if (kx_q != KM1) begin
                kx_q <= kx_q + 1'b1;
            end else begin
                kx_q <= '0;
                if (ky_q != KM1) begin
                    ky_q <= ky_q + 1'b1;
                end else begin
                    ky_q <= '0;
                    if (ox_q != OWM1) begin
                        ox_q <= ox_q + 1'b1;
                    end else begin
                        ox_q <= '0;
                        oy_q <= (oy_q != OHM1) ? oy_q + 1'b1 : '0;
                    end
                end
            end
        end
    end

    // Data pipeline: buffer data lands in the output register, or in the skid entry when stalled;
    // the skid entry always drains first so beat order is preserved.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            skid_vld_q      <= 1'b0;
            skid_last_q     <= 1'b0;
            skid_dat_q      <= '0;
            out_vld_q       <= 1'b0;
            out_last_q      <= 1'b0;
            out_dat_q       <= '0;
        end else begin
            inflight_q      <= issue_w;
            inflight_last_q <= issue_w && win_last_w;
            if (!out_vld_q || accept_w) begin
                if (skid_vld_q) begin
                    out_vld_q   <= 1'b1;
                    out_dat_q   <= skid_dat_q;
                    out_last_q  <= skid_last_q;
                    skid_vld_q  <= inflight_q;
                    skid_dat_q  <= i_conv_dout;
                    skid_last_q <= inflight_q && inflight_last_q;
                end else begin
                    out_vld_q  <= inflight_q;
                    out_last_q <= inflight_q && inflight_last_q;
                    if (inflight_q) out_dat_q <= i_conv_dout;
                end
            end else if (inflight_q) begin
                skid_vld_q  <= 1'b1;
                skid_dat_q  <= i_conv_dout;
                skid_last_q <= inflight_last_q;
            end
        end
    end

    assign o_win_vld         = out_vld_q;
    assign o_win_data        = out_dat_q;
    assign o_win_last        = out_last_q;
    assign o_switch_pingpong = switch_q;
    assign o_frame_done      = switch_q;

endmodule
